// File: rtl/core_pkg.sv
// Shared core types and constants.
// Forward-select encoding used by the operand fetch stage.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX,
        FWD_ZERO
    } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode/regfile/forward/execute bundle around the operand fetch stage.
// slave is the stage view, master is the surrounding pipeline.
interface operand_fetch_stage_if
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);

    logic                  Flush;
    logic                  Id_Valid;
    logic                  Id_Ready;
    logic [XLEN-1:0]       Id_Pc;
    logic [REG_ADDR_W-1:0] Id_Rs1_Addr;
    logic [REG_ADDR_W-1:0] Id_Rs2_Addr;
    logic                  Id_Rs1_Used;
    logic                  Id_Rs2_Used;
    logic [REG_ADDR_W-1:0] Id_Rd_Addr;
    logic                  Id_Rd_Wr;
    logic [XLEN-1:0]       Id_Imm;
    logic [CTRL_W-1:0]     Id_Ctrl;

    logic [REG_ADDR_W-1:0] Rf_Rd_Addr_1;
    logic [REG_ADDR_W-1:0] Rf_Rd_Addr_2;
    logic [XLEN-1:0]       Rf_Rd_Data_1;
    logic [XLEN-1:0]       Rf_Rd_Data_2;

    logic                  Exf_Valid;
    logic                  Exf_Is_Load;
    logic [REG_ADDR_W-1:0] Exf_Addr;
    logic [XLEN-1:0]       Exf_Data;
    logic                  Memf_Valid;
    logic [REG_ADDR_W-1:0] Memf_Addr;
    logic [XLEN-1:0]       Memf_Data;
    logic                  Wbf_Valid;
    logic [REG_ADDR_W-1:0] Wbf_Addr;
    logic [XLEN-1:0]       Wbf_Data;

    logic                  Ex_Valid;
    logic                  Ex_Ready;
    logic [XLEN-1:0]       Ex_Pc;
    logic [XLEN-1:0]       Ex_Rs1_Data;
    logic [XLEN-1:0]       Ex_Rs2_Data;
    logic [XLEN-1:0]       Ex_Imm;
    logic [REG_ADDR_W-1:0] Ex_Rd_Addr;
    logic                  Ex_Rd_Wr;
    logic [CTRL_W-1:0]     Ex_Ctrl;

    logic [CNT_W-1:0]      Stall_Cnt;
    fwd_sel_e              Rs1_Fwd_Sel;
    fwd_sel_e              Rs2_Fwd_Sel;

    modport slave (
        input  Flush, Id_Valid, Id_Pc,
        input  Id_Rs1_Addr, Id_Rs2_Addr,
        input  Id_Rs1_Used, Id_Rs2_Used,
        input  Id_Rd_Addr, Id_Rd_Wr,
        input  Id_Imm, Id_Ctrl,
        output Id_Ready,
        output Rf_Rd_Addr_1, Rf_Rd_Addr_2,
        input  Rf_Rd_Data_1, Rf_Rd_Data_2,
        input  Exf_Valid, Exf_Is_Load,
        input  Exf_Addr, Exf_Data,
        input  Memf_Valid, Memf_Addr, Memf_Data,
        input  Wbf_Valid, Wbf_Addr, Wbf_Data,
        output Ex_Valid,
        input  Ex_Ready,
        output Ex_Pc, Ex_Rs1_Data, Ex_Rs2_Data,
        output Ex_Imm, Ex_Rd_Addr, Ex_Rd_Wr,
        output Ex_Ctrl, Stall_Cnt,
        output Rs1_Fwd_Sel, Rs2_Fwd_Sel
    );

    modport master (
        output Flush, Id_Valid, Id_Pc,
        output Id_Rs1_Addr, Id_Rs2_Addr,
        output Id_Rs1_Used, Id_Rs2_Used,
        output Id_Rd_Addr, Id_Rd_Wr,
        output Id_Imm, Id_Ctrl,
        input  Id_Ready,
        input  Rf_Rd_Addr_1, Rf_Rd_Addr_2,
        output Rf_Rd_Data_1, Rf_Rd_Data_2,
        output Exf_Valid, Exf_Is_Load,
        output Exf_Addr, Exf_Data,
        output Memf_Valid, Memf_Addr, Memf_Data,
        output Wbf_Valid, Wbf_Addr, Wbf_Data,
        input  Ex_Valid,
        output Ex_Ready,
        input  Ex_Pc, Ex_Rs1_Data, Ex_Rs2_Data,
        input  Ex_Imm, Ex_Rd_Addr, Ex_Rd_Wr,
        input  Ex_Ctrl, Stall_Cnt,
        input  Rs1_Fwd_Sel, Rs2_Fwd_Sel
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// One-source operand select: x0, then EX, MEM, WB, then regfile.
// Youngest producer wins; loads in EX never forward.
module operand_fwd_mux
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       operand,
    output fwd_sel_e              sel
);

    logic ex_m;
    logic mem_m;
    logic wb_m;
    logic z_hit;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_m  = ex_valid & ~ex_is_load & (ex_addr == addr);
    assign mem_m = mem_valid & (mem_addr == addr);
    assign wb_m  = wb_valid & (wb_addr == addr);

    // One-hot hit terms keep the decoder below truly unique.
    assign z_hit   = (addr == '0);
    assign ex_hit  = ~z_hit & ex_m;
    assign mem_hit = ~z_hit & ~ex_m & mem_m;
    assign wb_hit  = ~z_hit & ~ex_m & ~mem_m & wb_m;

    always_comb begin
        sel     = FWD_RF;
        operand = rf_data;
        unique case (1'b1)
            z_hit: begin
                sel     = FWD_ZERO;
                operand = '0;
            end
            ex_hit: begin
                sel     = FWD_EX;
                operand = ex_data;
            end
            mem_hit: begin
                sel     = FWD_MEM;
                operand = mem_data;
            end
            wb_hit: begin
                sel     = FWD_WB;
                operand = wb_data;
            end
            default: begin
                sel     = FWD_RF;
                operand = rf_data;
            end
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: forwarding, load-use stall, one output slot.
// Slot holds bit-stable under backpressure; flush discards it.
module operand_fetch_stage
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core_N,
    operand_fetch_stage_if.slave  bus
);

    logic [XLEN-1:0]       rs1_op;
    logic [XLEN-1:0]       rs2_op;
    fwd_sel_e              rs1_sel;
    fwd_sel_e              rs2_sel;
    logic                  hazard;
    logic                  slot_free;
    logic                  ready;
    logic                  accept;

    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rs1;
    logic [XLEN-1:0]       ex_rs2;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_rd_wr;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [CNT_W-1:0]      stall_cnt;

    assign bus.Rf_Rd_Addr_1 = bus.Id_Rs1_Addr;
    assign bus.Rf_Rd_Addr_2 = bus.Id_Rs2_Addr;

    operand_fwd_mux #(.XLEN(XLEN)) u_rs1 (
        .addr       (bus.Id_Rs1_Addr),
        .rf_data    (bus.Rf_Rd_Data_1),
        .ex_valid   (bus.Exf_Valid),
        .ex_is_load (bus.Exf_Is_Load),
        .ex_addr    (bus.Exf_Addr),
        .ex_data    (bus.Exf_Data),
        .mem_valid  (bus.Memf_Valid),
        .mem_addr   (bus.Memf_Addr),
        .mem_data   (bus.Memf_Data),
        .wb_valid   (bus.Wbf_Valid),
        .wb_addr    (bus.Wbf_Addr),
        .wb_data    (bus.Wbf_Data),
        .operand    (rs1_op),
        .sel        (rs1_sel)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_rs2 (
        .addr       (bus.Id_Rs2_Addr),
        .rf_data    (bus.Rf_Rd_Data_2),
        .ex_valid   (bus.Exf_Valid),
        .ex_is_load (bus.Exf_Is_Load),
        .ex_addr    (bus.Exf_Addr),
        .ex_data    (bus.Exf_Data),
        .mem_valid  (bus.Memf_Valid),
        .mem_addr   (bus.Memf_Addr),
        .mem_data   (bus.Memf_Data),
        .wb_valid   (bus.Wbf_Valid),
        .wb_addr    (bus.Wbf_Addr),
        .wb_data    (bus.Wbf_Data),
        .operand    (rs2_op),
        .sel        (rs2_sel)
    );

    assign bus.Rs1_Fwd_Sel = rs1_sel;
    assign bus.Rs2_Fwd_Sel = rs2_sel;

    // A load still in EX has no data yet, so its consumer must wait.
    assign hazard = bus.Id_Valid & bus.Exf_Valid & bus.Exf_Is_Load
                  & (bus.Exf_Addr != '0)
                  & ((bus.Id_Rs1_Used & (bus.Exf_Addr == bus.Id_Rs1_Addr))
                  |  (bus.Id_Rs2_Used & (bus.Exf_Addr == bus.Id_Rs2_Addr)));

    assign slot_free = ~ex_valid | bus.Ex_Ready;
    assign ready     = Rst_Core_N & slot_free & ~hazard & ~bus.Flush;
    assign accept    = bus.Id_Valid & ready;
    assign bus.Id_Ready = ready;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_imm     <= '0;
            ex_rd_addr <= '0;
            ex_rd_wr   <= 1'b0;
            ex_ctrl    <= '0;
        end else if (bus.Flush) begin
            ex_valid <= 1'b0;
        end else if (slot_free) begin
            ex_valid <= accept;
            if (accept) begin
                ex_pc      <= bus.Id_Pc;
                ex_rs1     <= rs1_op;
                ex_rs2     <= rs2_op;
                ex_imm     <= bus.Id_Imm;
                ex_rd_addr <= bus.Id_Rd_Addr;
                ex_rd_wr   <= bus.Id_Rd_Wr;
                ex_ctrl    <= bus.Id_Ctrl;
            end
        end
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            stall_cnt <= '0;
        end else if (hazard & slot_free & ~bus.Flush) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.Ex_Valid    = ex_valid;
    assign bus.Ex_Pc       = ex_pc;
    assign bus.Ex_Rs1_Data = ex_rs1;
    assign bus.Ex_Rs2_Data = ex_rs2;
    assign bus.Ex_Imm      = ex_imm;
    assign bus.Ex_Rd_Addr  = ex_rd_addr;
    assign bus.Ex_Rd_Wr    = ex_rd_wr;
    assign bus.Ex_Ctrl     = ex_ctrl;
    assign bus.Stall_Cnt   = stall_cnt;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: vector table plus
// hand sequences for stall, backpressure, flush, saturation, reset.
module tb_operand_fetch_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    operand_fetch_stage_if #(.XLEN(32), .CTRL_W(16), .CNT_W(16)) ifc ();

    operand_fetch_stage #(.XLEN(32), .CTRL_W(16), .CNT_W(16)) dut (
        .Clk_Core   (clk),
        .Rst_Core_N (rst_n),
        .bus        (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        exv;
        logic        exl;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fwd();
        ifc.Exf_Valid   = 1'b0;
        ifc.Exf_Is_Load = 1'b0;
        ifc.Exf_Addr    = '0;
        ifc.Exf_Data    = '0;
        ifc.Memf_Valid  = 1'b0;
        ifc.Memf_Addr   = '0;
        ifc.Memf_Data   = '0;
        ifc.Wbf_Valid   = 1'b0;
        ifc.Wbf_Addr    = '0;
        ifc.Wbf_Data    = '0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1,
                          input logic u2);
        ifc.Id_Valid    = 1'b1;
        ifc.Id_Pc       = pc;
        ifc.Id_Rs1_Addr = rs1;
        ifc.Id_Rs2_Addr = rs2;
        ifc.Id_Rs1_Used = u1;
        ifc.Id_Rs2_Used = u2;
        ifc.Id_Rd_Addr  = 5'd1;
        ifc.Id_Rd_Wr    = 1'b1;
        ifc.Id_Imm      = pc + 32'd5;
        ifc.Id_Ctrl     = pc[15:0];
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifc.Flush    = 1'b0;
        ifc.Ex_Ready = 1'b1;
        ifc.Rf_Rd_Data_1 = '0;
        ifc.Rf_Rd_Data_2 = '0;
        idle_fwd();
        set_id(32'h0, 5'd0, 5'd0, 1'b1, 1'b0);

        //       rs1 rs2 u1 u2 rf1  rf2  exv exl exa exd  mv ma md  wv wa wd  exp1 exp2
        vecs[0] = '{0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    32'h0, 32'h0};
        vecs[1] = '{3, 0, 1, 0, 32'h10, 0, 1, 0, 3, 32'h40, 1, 3, 32'h30,
                    1, 3, 32'h20, 32'h40, 32'h0};
        vecs[2] = '{3, 0, 1, 0, 32'h10, 0, 0, 0, 3, 32'h40, 1, 3, 32'h30,
                    1, 3, 32'h20, 32'h30, 32'h0};
        vecs[3] = '{3, 0, 1, 0, 32'h10, 0, 0, 0, 3, 32'h40, 0, 3, 32'h30,
                    1, 3, 32'h20, 32'h20, 32'h0};
        vecs[4] = '{3, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    32'h10, 32'h0};
        vecs[5] = '{0, 2, 1, 1, 32'h5, 32'h22, 1, 0, 0, 32'h99, 1, 0,
                    32'h98, 0, 0, 0, 32'h0, 32'h22};
        vecs[6] = '{1, 7, 1, 0, 32'h11, 32'h70, 1, 1, 7, 32'hEE, 1, 7,
                    32'h55, 0, 0, 0, 32'h11, 32'h55};
        vecs[7] = '{4, 4, 1, 1, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 0, 1, 4,
                    32'hAB, 32'hAB, 32'hAB};
        vecs[8] = '{9, 6, 1, 1, 32'h3, 32'h66, 1, 0, 8, 32'h88, 1, 9,
                    32'h99, 1, 6, 32'h60, 32'h99, 32'h60};

        tick();
        chk("reset_ex_valid", 64'(ifc.Ex_Valid), 64'd0);
        chk("reset_stall_cnt", 64'(ifc.Stall_Cnt), 64'd0);
        chk("reset_ex_pc", 64'(ifc.Ex_Pc), 64'd0);
        chk("reset_id_ready", 64'(ifc.Id_Ready), 64'd0);
        rst_n = 1'b1;
        ifc.Id_Valid = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            set_id(32'h1000 + 32'(i * 4), vecs[i].rs1, vecs[i].rs2,
                   vecs[i].u1, vecs[i].u2);
            ifc.Rf_Rd_Data_1 = vecs[i].rf1;
            ifc.Rf_Rd_Data_2 = vecs[i].rf2;
            ifc.Exf_Valid    = vecs[i].exv;
            ifc.Exf_Is_Load  = vecs[i].exl;
            ifc.Exf_Addr     = vecs[i].exa;
            ifc.Exf_Data     = vecs[i].exd;
            ifc.Memf_Valid   = vecs[i].mv;
            ifc.Memf_Addr    = vecs[i].ma;
            ifc.Memf_Data    = vecs[i].md;
            ifc.Wbf_Valid    = vecs[i].wv;
            ifc.Wbf_Addr     = vecs[i].wa;
            ifc.Wbf_Data     = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_id_ready", i), 64'(ifc.Id_Ready), 64'd1);
            chk($sformatf("v%0d_rf_addr_1", i), 64'(ifc.Rf_Rd_Addr_1),
                64'(vecs[i].rs1));
            chk($sformatf("v%0d_rf_addr_2", i), 64'(ifc.Rf_Rd_Addr_2),
                64'(vecs[i].rs2));
            tick();
            chk($sformatf("v%0d_ex_valid", i), 64'(ifc.Ex_Valid), 64'd1);
            chk($sformatf("v%0d_rs1", i), 64'(ifc.Ex_Rs1_Data),
                64'(vecs[i].exp1));
            chk($sformatf("v%0d_rs2", i), 64'(ifc.Ex_Rs2_Data),
                64'(vecs[i].exp2));
            chk($sformatf("v%0d_pc", i), 64'(ifc.Ex_Pc),
                64'(32'h1000 + 32'(i * 4)));
        end
        chk("v0_no_stall", 64'(ifc.Stall_Cnt), 64'd0);

        // Load-use stall then MEM forward.
        idle_fwd();
        set_id(32'h2000, 5'd0, 5'd5, 1'b0, 1'b1);
        ifc.Exf_Valid   = 1'b1;
        ifc.Exf_Is_Load = 1'b1;
        ifc.Exf_Addr    = 5'd5;
        #1;
        chk("lu_id_ready", 64'(ifc.Id_Ready), 64'd0);
        tick();
        chk("lu_bubble", 64'(ifc.Ex_Valid), 64'd0);
        chk("lu_stall_cnt", 64'(ifc.Stall_Cnt), 64'd1);
        idle_fwd();
        ifc.Memf_Valid = 1'b1;
        ifc.Memf_Addr  = 5'd5;
        ifc.Memf_Data  = 32'h77;
        #1;
        chk("lu_ready2", 64'(ifc.Id_Ready), 64'd1);
        tick();
        chk("lu_valid2", 64'(ifc.Ex_Valid), 64'd1);
        chk("lu_rs2", 64'(ifc.Ex_Rs2_Data), 64'h77);
        chk("lu_stall_cnt2", 64'(ifc.Stall_Cnt), 64'd1);

        // Backpressure hold for 3 cycles, then back-to-back accept.
        idle_fwd();
        set_id(32'h3000, 5'd0, 5'd0, 1'b0, 1'b0);
        ifc.Ex_Ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_ready", c), 64'(ifc.Id_Ready), 64'd0);
            tick();
            chk($sformatf("hold%0d_valid", c), 64'(ifc.Ex_Valid), 64'd1);
            chk($sformatf("hold%0d_pc", c), 64'(ifc.Ex_Pc), 64'h2000);
            chk($sformatf("hold%0d_rs2", c), 64'(ifc.Ex_Rs2_Data), 64'h77);
            chk($sformatf("hold%0d_imm", c), 64'(ifc.Ex_Imm), 64'h2005);
        end
        ifc.Ex_Ready = 1'b1;
        #1;
        chk("release_ready", 64'(ifc.Id_Ready), 64'd1);
        tick();
        chk("b2b_valid", 64'(ifc.Ex_Valid), 64'd1);
        chk("b2b_pc", 64'(ifc.Ex_Pc), 64'h3000);

        // Flush discards a held slot and blocks accept.
        set_id(32'h4000, 5'd0, 5'd0, 1'b0, 1'b0);
        ifc.Ex_Ready = 1'b0;
        ifc.Flush    = 1'b1;
        #1;
        chk("flush_ready", 64'(ifc.Id_Ready), 64'd0);
        tick();
        chk("flush_valid", 64'(ifc.Ex_Valid), 64'd0);
        ifc.Flush    = 1'b0;
        ifc.Id_Valid = 1'b0;
        ifc.Ex_Ready = 1'b1;
        tick();
        chk("flush_no_accept", 64'(ifc.Ex_Valid), 64'd0);

        // Counter saturation.
        set_id(32'h5000, 5'd6, 5'd0, 1'b1, 1'b0);
        ifc.Exf_Valid   = 1'b1;
        ifc.Exf_Is_Load = 1'b1;
        ifc.Exf_Addr    = 5'd6;
        for (int n = 0; n < 70000 && ifc.Stall_Cnt != 16'hFFFE; n++) begin
            tick();
        end
        chk("sat_reach", 64'(ifc.Stall_Cnt), 64'hFFFE);
        tick();
        chk("sat_first", 64'(ifc.Stall_Cnt), 64'hFFFF);
        tick();
        chk("sat_hold", 64'(ifc.Stall_Cnt), 64'hFFFF);
        chk("sat_bubble", 64'(ifc.Ex_Valid), 64'd0);

        // Reset mid-hold drops the slot at once.
        idle_fwd();
        tick();
        chk("pre_rst_valid", 64'(ifc.Ex_Valid), 64'd1);
        ifc.Ex_Ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(ifc.Ex_Valid), 64'd0);
        chk("rst_cnt", 64'(ifc.Stall_Cnt), 64'd0);
        chk("rst_ready", 64'(ifc.Id_Ready), 64'd0);
        chk("rst_pc", 64'(ifc.Ex_Pc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
